// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM state type, default widths and width helper for the SRAM arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} arb_state_t;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 24;

   // Never returns 0, so single-entry ranges still get a 1-bit signal.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sram_arb_picker.sv
// sram_arb_picker: combinational winner selection, fixed priority or round-robin.
// Round-robin search order is enabled by SRAM_ARB_ROUND_ROBIN_EN.
module sram_arb_picker
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IW      = clog2_safe(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req_i,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   input  logic [IW-1:0]      last_i,
`endif
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               any_o
);

   assign any_o = |req_i;
   assign gnt_o = any_o ? NUM_REQ'(1) << idx_o : '0;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic [IW-1:0]        start;
   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [IW-1:0]        off;
   logic [IW:0]          sum;

   // Rotate requests so the search begins just after the last winner.
   always_comb begin
      start = (last_i == IW'(NUM_REQ-1)) ? '0 : last_i + 1'b1;
      dbl   = {req_i, req_i} >> start;
      rot   = dbl[NUM_REQ-1:0];
      off   = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) if (rot[k]) off = IW'(k);
      sum   = {1'b0, start} + {1'b0, off};
      idx_o = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
   end
`else
   always_comb begin
      idx_o = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) if (req_i[k]) idx_o = IW'(k);
   end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM among NUM_REQ requesters, one timed access at a time.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ       = 2,
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int ACCESS_CYCLES = 2,
   localparam int IW           = clog2_safe(NUM_REQ),
   localparam int CW           = clog2_safe(ACCESS_CYCLES+1)
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic [IW-1:0]             grant_id,
   output logic                      busy,
   output logic                      read_enable,
   output logic                      write_enable,
   output logic [ADDR_W-1:0]         address,
   output logic [DATA_W-1:0]         w_data,
   input  logic [DATA_W-1:0]         r_data
);

   arb_state_t         state_q;
   logic [CW-1:0]      cnt_q;
   logic [NUM_REQ-1:0] ack_q;
   logic [DATA_W-1:0]  rdata_q;
   logic [IW-1:0]      grant_id_q;
   logic               busy_q;
   logic               re_q;
   logic               we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               sel_we;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic [IW-1:0] last_q;

   // Starts at the top index so requester 0 is first after reset.
   always_ff @(posedge clk) begin
      if (rst) last_q <= IW'(NUM_REQ-1);
      else if (state_q == IDLE && pick_any) last_q <= pick_idx;
   end
`endif

   sram_arb_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
      .req_i  (req),
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      .last_i (last_q),
`endif
      .gnt_o  (pick_gnt),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sel_addr  = pick_gnt[k] ? req_addr[k*ADDR_W +: ADDR_W]   : sel_addr;
         sel_wdata = pick_gnt[k] ? req_wdata[k*DATA_W +: DATA_W]  : sel_wdata;
         sel_we    = pick_gnt[k] ? we[k]                          : sel_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ack_q      <= '0;
         rdata_q    <= '0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         re_q       <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (pick_any) begin
               grant_id_q <= pick_idx;
               addr_q     <= sel_addr;
               wdata_q    <= sel_wdata;
               re_q       <= ~sel_we;
               we_q       <= sel_we;
               cnt_q      <= CW'(ACCESS_CYCLES-1);
               busy_q     <= 1'b1;
               state_q    <= ACCESS;
            end
            ACCESS: if (cnt_q == '0) begin
               if (re_q) rdata_q <= r_data;
               re_q    <= 1'b0;
               we_q    <= 1'b0;
               ack_q   <= NUM_REQ'(1) << grant_id_q;
               state_q <= ACK;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
            ACK: begin
               ack_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack          = ack_q;
   assign rdata        = rdata_q;
   assign grant_id     = grant_id_q;
   assign busy         = busy_q;
   assign read_enable  = re_q;
   assign write_enable = we_q;
   assign address      = addr_q;
   assign w_data       = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus with a scoreboard queue checked by an ack monitor.
module tb_sram_arbiter;

   localparam int N  = 2;
   localparam int AW = 16;
   localparam int DW = 24;
   localparam int AC = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, we, ack;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rdata, w_data, r_data;
   logic [0:0]      grant_id;
   logic            busy, read_enable, write_enable;
   logic [AW-1:0]   address;
   logic [DW-1:0]   mem [0:65535];

   typedef struct {int id; bit rd; logic [DW-1:0] data;} exp_t;
   exp_t exp_q[$];
   exp_t e;
   int checks = 0;
   int errors = 0;
   int run = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .req_addr(req_addr), .req_wdata(req_wdata),
      .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
      .read_enable(read_enable), .write_enable(write_enable), .address(address),
      .w_data(w_data), .r_data(r_data)
   );

   // SRAM model
   assign r_data = read_enable ? mem[address] : '0;
   always @(posedge clk) if (write_enable) mem[address] <= w_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected entry per ack and checks strobe timing.
   always @(negedge clk) begin
      if (read_enable | write_enable) begin
         chk("strobe_excl", read_enable & write_enable, 0);
         run++;
      end
      if (|ack) begin
         chk("ack_strobes_low", {read_enable, write_enable}, 0);
         chk("enable_cycles", run, AC);
         run = 0;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack=%b expected none", ack);
         end else begin
            e = exp_q.pop_front();
            chk("ack_vec", ack, N'(1) << e.id);
            chk("grant_id", grant_id, e.id);
            if (e.rd) chk("rdata", rdata, e.data);
         end
      end else if (!busy) run = 0;
   end

   task automatic wait_ack(input int id, output int t);
      t = 0;
      while (!ack[id] && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!ack[id]) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack[%0d] expected ack within 20 cycles", id);
      end
   endtask

   // d is write data for a write, expected read data for a read.
   task automatic access(input int id, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit probe);
      int t;
      exp_q.push_back('{id, !w, d});
      @(posedge clk);
      #1;
      req[id] = 1'b1;
      we[id] = w;
      req_addr[id*AW +: AW] = a;
      req_wdata[id*DW +: DW] = w ? d : 24'h5A5A5A;
      if (probe) begin
         @(posedge clk);
         @(negedge clk);
         chk("we_strobe", write_enable, w);
         chk("re_strobe", read_enable, !w);
         chk("address", address, a);
         if (w) chk("w_data", w_data, d);
         chk("busy", busy, 1);
      end
      wait_ack(id, t);
      if (probe) chk("ack_latency", t, AC);
      req[id] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t;
      rst = 1'b1;
      req = '0;
      we = '0;
      req_addr = '0;
      req_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_re", read_enable, 0);
      chk("rst_we", write_enable, 0);
      chk("rst_addr", address, 0);
      chk("rst_wdata", w_data, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // write then read back through the other requester
      access(0, 1'b1, 16'h0010, 24'hA1B2C3, 1'b1);
      access(1, 1'b0, 16'h0010, 24'hA1B2C3, 1'b1);

      // contention: two reads held continuously
      access(0, 1'b1, 16'h0001, 24'h111111, 1'b1);
      access(1, 1'b1, 16'h0002, 24'h222222, 1'b1);
      for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         exp_q.push_back('{i % 2, 1'b1, (i % 2) ? 24'h222222 : 24'h111111});
`else
         exp_q.push_back('{0, 1'b1, 24'h111111});
`endif
      end
      @(posedge clk);
      #1;
      we = '0;
      req_addr = {16'h0002, 16'h0001};
      req = 2'b11;
      n = 0;
      t = 0;
      while (n < 4 && t < 60) begin
         @(negedge clk);
         t++;
         if (|ack) n++;
      end
      req = '0;
      chk("contention_acks", n, 4);

      // back-to-back at top address
      access(0, 1'b1, 16'hFFFF, 24'hFFFFFF, 1'b1);
      access(1, 1'b0, 16'hFFFF, 24'hFFFFFF, 1'b1);

      // reset during the second access cycle
      @(posedge clk);
      #1;
      req[0] = 1'b1;
      we[0] = 1'b1;
      req_addr[0 +: AW] = 16'h0030;
      req_wdata[0 +: DW] = 24'h123456;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      req[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_ack", ack, 0);
      chk("mid_rst_rdata", rdata, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_strobes", {read_enable, write_enable}, 0);
      chk("mid_rst_addr", address, 0);
      chk("mid_rst_wdata", w_data, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      access(1, 1'b0, 16'hFFFF, 24'hFFFFFF, 1'b1);

      // requester drops req mid-access
      exp_q.push_back('{0, 1'b1, 24'hA1B2C3});
      @(posedge clk);
      #1;
      req[0] = 1'b1;
      we[0] = 1'b0;
      req_addr[0 +: AW] = 16'h0010;
      @(posedge clk);
      @(posedge clk);
      #1 req[0] = 1'b0;
      wait_ack(0, t);
      repeat (6) @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_strobes", {read_enable, write_enable}, 0);
      chk("sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
